codec_cfg_seq: RTL and testbench
================================

Name: codec_cfg_seq

Overview:
- Parametrised audio-codec (WM8731-class) configuration sequencer.
- After reset it writes a 10-entry init table over a built-in I2C write master and reports done or error.
- It then stays live: it issues single-register update writes for headphone volume (up/down pulses) and input-source changes.
- It sits between board controls and the codec I2C pins, beside the audio ADC/DAC datapath.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- I2C_FREQ, 20000: SCL frequency in Hz; quarter-period divider DIV = CLK_FREQ/(4*I2C_FREQ), must be ≥1.
- DEV_ADDR, 8'h34: codec write address byte.
- MAX_RETRY, 3: re-attempts per write after a NACK before error.
- VOL_DEFAULT, 7'h79: headphone volume after reset.
- VOL_MIN, 7'h30: lower volume bound (mute region).
- VOL_MAX, 7'h7F: upper volume bound (+6 dB).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vol_up  in  1  one-cycle pulse (already synchronised): volume +1.
- vol_dn  in  1  one-cycle pulse: volume −1.
- src_sel  in  2  analog source: 0 line→DAC, 1 mic, 2 line bypass, 3 treated as 0.
- cur_vol  out  7  current volume code.
- busy  out  1  an I2C transaction is in flight.
- cfg_done  out  1  init table complete, sticky until reset.
- cfg_err  out  1  retry limit exhausted, sticky until reset.
- I2C_SCLK  out  1  I2C clock, push-pull.
- I2C_SDAT  inout  1  I2C data, open-drain (drives 0 or z).

Behaviour:
- Reset (asynchronous):
  - cur_vol=VOL_DEFAULT; busy, cfg_done, cfg_err = 0; I2C_SCLK=1; I2C_SDAT=z.
  - Pending flags cleared; FSM to INIT with index 0.
  - Reset mid-transaction aborts immediately, no STOP is generated.
- Frame format: START, DEV_ADDR, {reg[6:0], data[8]}, data[7:0], with an ACK slot after each byte, then STOP.
- Bit timing: each bit is 4 DIV ticks. SDA changes only while SCL is low; ACK is sampled on the SCL-high mid-phase.
- NACK: any NACK in the frame marks the whole frame NACK; STOP is still sent.
- Init table (reg, data[8:0]):
  - 0: 0x017; 1: 0x017.
  - 2: {1'b1 (LRHPBOTH), 1'b0, cur_vol}; 3: {2'b00, cur_vol}.
  - 4: path(src_sel); 5: 0x006; 6: 0x000; 7: 0x04D; 8: 0x000; 9: 0x001.
  - path: 0 → 0x012; 1 → 0x015; 2 → 0x01A; 3 → 0x012.
  - Table values are sampled when each entry is loaded.
  - Loading entry 2 clears vol_pend; loading entry 4 latches src_last and clears src_pend.
- FSM states: INIT_LOAD → XFER → CHECK.
  - ACK: advance to the next entry and reset the retry count.
  - NACK with retries < MAX_RETRY: retry count +1, reload the same entry.
  - NACK with retries = MAX_RETRY: go to ERR.
  - After entry 9 is ACKed: cfg_done=1, go to IDLE.
- IDLE: if vol_pend, write reg 2 = {1,0,cur_vol}; else if src_pend, write reg 4 = path(src_sel). Volume has priority. Both use the same XFER/CHECK/retry path and return to IDLE.
- ERR: cfg_err=1, bus released (SCL=1, SDA=z), no further writes until reset.
- Volume arithmetic:
  - vol_up at VOL_MAX and vol_dn at VOL_MIN are ignored (saturate, no pending).
  - vol_up and vol_dn in the same cycle are ignored.
  - A valid step updates cur_vol on the next cycle and sets vol_pend, in any state including INIT and XFER.
  - A step during XFER coalesces: at most one pending write, carrying the latest value.
- Source changes: src_pend is set when path(src_sel) ≠ src_last (registered compare), except in ERR.
- busy=1 from START until STOP completes.
- Transaction latency: roughly 29 SCL periods per write.

Decomposition:
- Shared package codec_cfg_pkg holds:
  - the register-address constants;
  - the init data constants;
  - the path() encoding;
  - the FSM state typedef.
- One sub-module, i2c_wr24_master, handles the frame:
  - Inputs: CLOCK_50, reset, go, data[23:0].
  - Outputs: done (1-cycle pulse), nack, SCL, SDA.
  - It owns the DIV tick counter.
- codec_cfg_seq owns the table, retry logic, volume counter and pending flags.

Test Plan:
- Always-ACK slave model: after reset, exactly 10 frames in order; frame 2 bytes 0x34 0x05 0x79, frame 9 bytes 0x34 0x12 0x01. Then cfg_done=1 and busy=0.
- Slave NACKs entry 3 twice, then ACKs: entry 3 appears 3 times, sequence completes, cfg_err=0.
- Slave always NACKs entry 0: exactly MAX_RETRY+1 = 4 frames, then cfg_err=1, SCL=1, SDA=z, and no further frames.
- After done, pulse vol_dn once: cur_vol=0x78 and one frame 0x34 0x05 0x78. Force cur_vol to 0x7F and pulse vol_up: no change, no frame. vol_up and vol_dn together: no change.
- After done, set src_sel 0→1: one frame 0x34 0x08 0x15. Three vol_up pulses during that frame: exactly one follow-up frame with the final volume.
- Assert reset in the middle of frame 5: SCL=1 and SDA=z immediately, then a full restart from entry 0.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - register map, init data, path encoding and FSM states for the codec sequencer
package codec_cfg_pkg;

  localparam logic [6:0] REG_LLIN   = 7'h00;
  localparam logic [6:0] REG_RLIN   = 7'h01;
  localparam logic [6:0] REG_LHP    = 7'h02;
  localparam logic [6:0] REG_RHP    = 7'h03;
  localparam logic [6:0] REG_APATH  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWR    = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;

  localparam logic [8:0] DAT_LIN    = 9'h017;
  localparam logic [8:0] DAT_DPATH  = 9'h006;
  localparam logic [8:0] DAT_PWR    = 9'h000;
  localparam logic [8:0] DAT_IFACE  = 9'h04D;
  localparam logic [8:0] DAT_SRATE  = 9'h000;
  localparam logic [8:0] DAT_ACTIVE = 9'h001;

  localparam logic [8:0] PATH_LINE   = 9'h012;
  localparam logic [8:0] PATH_MIC    = 9'h015;
  localparam logic [8:0] PATH_BYPASS = 9'h01A;

  localparam logic [3:0] LAST_ENTRY = 4'd9;

  typedef enum logic [2:0] {ST_INIT_LOAD, ST_XFER, ST_CHECK, ST_IDLE, ST_ERR} state_t;
  typedef enum logic [1:0] {PH_START, PH_BIT, PH_STOP} phase_t;

  // Source code 3 is unused on the board and falls back to the line-to-DAC path.
  function automatic logic [8:0] path(input logic [1:0] src);
    case (src)
      2'd1:    path = PATH_MIC;
      2'd2:    path = PATH_BYPASS;
      default: path = PATH_LINE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_wr24_master.sv
// rtl/i2c_wr24_master.sv - one-shot I2C write: START, three bytes each with an ACK slot, STOP
module i2c_wr24_master
  import codec_cfg_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        go,
  input  logic [23:0] data,
  input  logic        sda_pin,
  output logic        done,
  output logic        nack,
  output logic        scl,
  output logic        sda_low
);

  localparam int          DIV      = CLK_FREQ / (4 * I2C_FREQ);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  logic [15:0] div_cnt;
  logic [1:0]  q;
  logic [3:0]  bcnt;
  logic [1:0]  bytec;
  logic [23:0] shreg;
  logic        active;
  phase_t      phase;
  logic        tick, ack_slot, scl_n, low_n;

  assign tick     = (div_cnt == DIV_LAST);
  assign ack_slot = (phase == PH_BIT) && (bcnt == 4'd8);

  // Each slot is four quarters; SDA only moves in quarter 0 while SCL is low.
  always_comb begin
    scl_n = 1'b1;
    low_n = 1'b0;
    if (active) begin
      case (phase)
        PH_START: begin
          scl_n = (q != 2'd3);
          low_n = (q != 2'd0);
        end
        PH_BIT: begin
          scl_n = (q == 2'd1) || (q == 2'd2);
          low_n = !ack_slot && !shreg[23];
        end
        default: begin
          scl_n = (q != 2'd0);
          low_n = (q < 2'd2);
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      phase   <= PH_START;
      div_cnt <= '0;
      q       <= '0;
      bcnt    <= '0;
      bytec   <= '0;
      shreg   <= '0;
      done    <= 1'b0;
      nack    <= 1'b0;
      scl     <= 1'b1;
      sda_low <= 1'b0;
    end else begin
      done    <= 1'b0;
      scl     <= scl_n;
      sda_low <= low_n;
      if (!active) begin
        div_cnt <= '0;
        q       <= '0;
        phase   <= PH_START;
        bcnt    <= '0;
        bytec   <= '0;
        if (go) begin
          active <= 1'b1;
          shreg  <= data;
          nack   <= 1'b0;
        end
      end else if (!tick) begin
        div_cnt <= div_cnt + 16'd1;
      end else begin
        div_cnt <= '0;
        q       <= q + 2'd1;
        // Any byte left unacknowledged flags the whole frame.
        if (ack_slot && q == 2'd1 && sda_pin) nack <= 1'b1;
        if (q == 2'd3) begin
          case (phase)
            PH_START: phase <= PH_BIT;
            PH_BIT: begin
              if (ack_slot) begin
                bcnt <= '0;
                if (bytec == 2'd2) phase <= PH_STOP;
                else bytec <= bytec + 2'd1;
              end else begin
                bcnt  <= bcnt + 4'd1;
                shreg <= {shreg[22:0], 1'b0};
              end
            end
            default: begin
              active <= 1'b0;
              done   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// rtl/codec_cfg_seq.sv - codec init table, retry handling and live volume/source register updates
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int         CLK_FREQ    = 50000000,
  parameter int         I2C_FREQ    = 20000,
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         MAX_RETRY   = 3,
  parameter logic [6:0] VOL_DEFAULT = 7'h79,
  parameter logic [6:0] VOL_MIN     = 7'h30,
  parameter logic [6:0] VOL_MAX     = 7'h7F
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       vol_up,
  input  logic       vol_dn,
  input  logic [1:0] src_sel,
  output logic [6:0] cur_vol,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic       I2C_SCLK,
  inout  wire        I2C_SDAT
);

  localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY);

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [7:0] retry, retry_n;
  logic       upd, upd_n;
  logic       go, ld, done_set, err_set;
  logic       vol_pend, src_pend;
  logic [8:0] src_last;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       m_done, m_nack, sda_low;
  logic       step_up, step_dn;

  // Entries 2 and 4 double as the live update writes, so values are sampled at load time.
  always_comb begin
    reg_addr = REG_ACTIVE;
    reg_data = DAT_ACTIVE;
    case (idx)
      4'd0: begin reg_addr = REG_LLIN;  reg_data = DAT_LIN;               end
      4'd1: begin reg_addr = REG_RLIN;  reg_data = DAT_LIN;               end
      4'd2: begin reg_addr = REG_LHP;   reg_data = {1'b1, 1'b0, cur_vol}; end
      4'd3: begin reg_addr = REG_RHP;   reg_data = {2'b00, cur_vol};      end
      4'd4: begin reg_addr = REG_APATH; reg_data = path(src_sel);         end
      4'd5: begin reg_addr = REG_DPATH; reg_data = DAT_DPATH;             end
      4'd6: begin reg_addr = REG_PWR;   reg_data = DAT_PWR;               end
      4'd7: begin reg_addr = REG_IFACE; reg_data = DAT_IFACE;             end
      4'd8: begin reg_addr = REG_SRATE; reg_data = DAT_SRATE;             end
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    retry_n  = retry;
    upd_n    = upd;
    go       = 1'b0;
    ld       = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_INIT_LOAD: begin
        go      = 1'b1;
        ld      = 1'b1;
        state_n = ST_XFER;
      end
      ST_XFER: if (m_done) state_n = ST_CHECK;
      ST_CHECK: begin
        if (!m_nack) begin
          retry_n = '0;
          if (upd) begin
            state_n = ST_IDLE;
          end else if (idx == LAST_ENTRY) begin
            done_set = 1'b1;
            upd_n    = 1'b1;
            state_n  = ST_IDLE;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = ST_INIT_LOAD;
          end
        end else if (retry < RETRY_LAST) begin
          retry_n = retry + 8'd1;
          state_n = ST_INIT_LOAD;
        end else begin
          err_set = 1'b1;
          state_n = ST_ERR;
        end
      end
      ST_IDLE: begin
        if (vol_pend) begin
          idx_n   = 4'd2;
          state_n = ST_INIT_LOAD;
        end else if (src_pend) begin
          idx_n   = 4'd4;
          state_n = ST_INIT_LOAD;
        end
      end
      ST_ERR: ;
      default: state_n = ST_ERR;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT_LOAD;
      idx      <= '0;
      retry    <= '0;
      upd      <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      retry <= retry_n;
      upd   <= upd_n;
      if (done_set) cfg_done <= 1'b1;
      if (err_set)  cfg_err  <= 1'b1;
    end
  end

  assign step_up = vol_up && !vol_dn && (cur_vol < VOL_MAX);
  assign step_dn = vol_dn && !vol_up && (cur_vol > VOL_MIN);

  // A fresh step beats the clear so a step landing on the load cycle is not lost.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cur_vol  <= VOL_DEFAULT;
      vol_pend <= 1'b0;
      src_pend <= 1'b0;
      src_last <= PATH_LINE;
    end else begin
      if (step_up)      cur_vol <= cur_vol + 7'd1;
      else if (step_dn) cur_vol <= cur_vol - 7'd1;
      if (step_up || step_dn)   vol_pend <= 1'b1;
      else if (ld && idx == 4'd2) vol_pend <= 1'b0;
      if (ld && idx == 4'd4) begin
        src_last <= path(src_sel);
        src_pend <= 1'b0;
      end else if (state != ST_ERR && path(src_sel) != src_last) begin
        src_pend <= 1'b1;
      end
    end
  end

  assign busy     = (state == ST_XFER);
  assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

  i2c_wr24_master #(
    .CLK_FREQ(CLK_FREQ),
    .I2C_FREQ(I2C_FREQ)
  ) u_master (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .go      (go),
    .data    ({DEV_ADDR, reg_addr, reg_data}),
    .sda_pin (I2C_SDAT),
    .done    (m_done),
    .nack    (m_nack),
    .scl     (I2C_SCLK),
    .sda_low (sda_low)
  );

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb/tb_codec_cfg_seq.sv - scoreboard bench with an I2C slave model for codec_cfg_seq
module tb_codec_cfg_seq;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       vol_up   = 1'b0;
  logic       vol_dn   = 1'b0;
  logic [1:0] src_sel  = 2'd0;
  logic [6:0] cur_vol;
  logic       busy, cfg_done, cfg_err, I2C_SCLK;
  wire        I2C_SDAT;

  logic slv_drive = 1'b0;
  pullup (I2C_SDAT);
  assign I2C_SDAT = slv_drive ? 1'b0 : 1'bz;

  always #5 CLOCK_50 = ~CLOCK_50;

  codec_cfg_seq #(
    .CLK_FREQ(800000),
    .I2C_FREQ(100000)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .vol_up  (vol_up),
    .vol_dn  (vol_dn),
    .src_sel (src_sel),
    .cur_vol (cur_vol),
    .busy    (busy),
    .cfg_done(cfg_done),
    .cfg_err (cfg_err),
    .I2C_SCLK(I2C_SCLK),
    .I2C_SDAT(I2C_SDAT)
  );

  int n_vec = 0;
  int n_err = 0;
  int frames_seen = 0;
  logic [23:0] exp_q[$];
  logic [23:0] init_tab[0:9];
  logic [6:0] nack_reg = 7'h00;
  int nack_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model and frame monitor: decodes START/bytes/STOP, ACKs per policy, scores each frame.
  logic p_scl = 1'b1, p_sda = 1'b1, in_fr = 1'b0;
  int bitc = 0, bytec = 0;
  logic [7:0] sh = 8'h00;
  logic [23:0] fr = 24'h0;
  always @(negedge CLOCK_50) begin
    if (reset) begin
      slv_drive = 1'b0;
      in_fr = 1'b0;
      p_scl = I2C_SCLK;
      p_sda = I2C_SDAT;
    end else begin
      if (p_scl && I2C_SCLK && p_sda && !I2C_SDAT) begin
        in_fr = 1'b1; bitc = 0; bytec = 0;
      end else if (p_scl && I2C_SCLK && !p_sda && I2C_SDAT) begin
        if (in_fr && bytec == 3) begin
          frames_seen++;
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_frame: got %h expected none", fr);
          end else begin
            check("frame", fr, exp_q.pop_front());
          end
        end
        in_fr = 1'b0;
      end else if (in_fr && !p_scl && I2C_SCLK) begin
        if (bitc < 8) sh = {sh[6:0], I2C_SDAT};
        bitc++;
      end else if (in_fr && p_scl && !I2C_SCLK) begin
        if (bitc == 8) begin
          fr = {fr[15:0], sh};
          if (bytec == 1 && sh[7:1] == nack_reg && nack_left > 0) begin
            slv_drive = 1'b0;
            nack_left--;
          end else begin
            slv_drive = 1'b1;
          end
        end else if (bitc == 9) begin
          slv_drive = 1'b0; bitc = 0; bytec++;
        end
      end
      p_scl = I2C_SCLK;
      p_sda = I2C_SDAT;
    end
  end

  task automatic push_init();
    for (int i = 0; i < 10; i++) exp_q.push_back(init_tab[i]);
  endtask

  task automatic hold_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic release_reset();
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    repeat (8) @(negedge CLOCK_50);
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("busy_wait", busy, lvl);
  endtask

  task automatic pulse(input logic up, input logic dn);
    @(posedge CLOCK_50);
    #1 vol_up = up; vol_dn = dn;
    @(posedge CLOCK_50);
    #1 vol_up = 1'b0; vol_dn = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int n;
    init_tab = '{24'h340017, 24'h340217, 24'h340579, 24'h340679, 24'h340812,
                 24'h340A06, 24'h340C00, 24'h340E4D, 24'h341000, 24'h341201};

    // Reset state, then a clean init sequence against an always-ACK slave.
    repeat (3) @(negedge CLOCK_50);
    check("rst_cur_vol", cur_vol, 7'h79);
    check("rst_busy", busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_scl", I2C_SCLK, 1);
    check("rst_sda", I2C_SDAT, 1);
    push_init();
    release_reset();
    wait_drain("init_drain", 4000);
    check("init_done", cfg_done, 1);
    check("init_busy", busy, 0);
    check("init_err", cfg_err, 0);

    // Entry 3 NACKed twice, then accepted.
    hold_reset();
    nack_reg = 7'h03; nack_left = 2;
    for (int i = 0; i < 4; i++) exp_q.push_back(init_tab[i]);
    exp_q.push_back(init_tab[3]);
    exp_q.push_back(init_tab[3]);
    for (int i = 4; i < 10; i++) exp_q.push_back(init_tab[i]);
    release_reset();
    wait_drain("retry_drain", 5000);
    check("retry_done", cfg_done, 1);
    check("retry_err", cfg_err, 0);

    // Entry 0 always NACKed: four attempts then the error state.
    hold_reset();
    nack_reg = 7'h00; nack_left = 1000;
    for (int i = 0; i < 4; i++) exp_q.push_back(init_tab[0]);
    snap = frames_seen;
    release_reset();
    n = 0;
    while (!cfg_err && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("err_flag", cfg_err, 1);
    repeat (800) @(negedge CLOCK_50);
    check("err_frames", frames_seen - snap, 4);
    check("err_scl", I2C_SCLK, 1);
    check("err_sda", I2C_SDAT, 1);
    check("err_busy", busy, 0);
    check("err_done", cfg_done, 0);
    nack_left = 0;

    // Live updates after a clean init.
    hold_reset();
    push_init();
    release_reset();
    wait_drain("live_init_drain", 4000);
    exp_q.push_back(24'h340578);
    pulse(1'b0, 1'b1);
    wait_drain("vol_dn_drain", 1000);
    check("vol_dn_value", cur_vol, 7'h78);

    exp_q.push_back(24'h340815);
    exp_q.push_back(24'h34057B);
    @(posedge CLOCK_50);
    #1 src_sel = 2'd1;
    wait_busy(1'b1, 100);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    wait_drain("src_mic_drain", 1500);
    check("coalesce_vol", cur_vol, 7'h7B);

    exp_q.push_back(24'h34081A);
    exp_q.push_back(24'h34057F);
    @(posedge CLOCK_50);
    #1 src_sel = 2'd2;
    wait_busy(1'b1, 100);
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0);
    wait_drain("src_byp_drain", 1500);
    check("sat_climb_vol", cur_vol, 7'h7F);

    snap = frames_seen;
    pulse(1'b1, 1'b0);
    repeat (600) @(negedge CLOCK_50);
    check("sat_max_vol", cur_vol, 7'h7F);
    check("sat_max_frames", frames_seen - snap, 0);
    pulse(1'b1, 1'b1);
    repeat (600) @(negedge CLOCK_50);
    check("both_vol", cur_vol, 7'h7F);
    check("both_frames", frames_seen - snap, 0);

    // Reset landing inside frame 5 releases the bus at once and restarts from entry 0.
    hold_reset();
    src_sel = 2'd0;
    push_init();
    snap = frames_seen;
    release_reset();
    n = 0;
    while (frames_seen < snap + 5 && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("mid_frames_before", frames_seen - snap, 5);
    wait_busy(1'b0, 100);
    wait_busy(1'b1, 100);
    repeat (42) @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    check("mid_rst_scl", I2C_SCLK, 1);
    check("mid_rst_sda", I2C_SDAT, 1);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    push_init();
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    wait_drain("restart_drain", 4000);
    check("restart_done", cfg_done, 1);
    check("restart_err", cfg_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
